// File: rtl/pwm_dc_ramp_if.sv
// Signal bundle between a duty-cycle requester/consumer and pwm_dc_ramp.
// master: the side that issues targets/config and watches the ramp output.
// slave:  the ramp generator itself.
interface pwm_dc_ramp_if #(
  parameter int DW = 16,
  parameter int IW = 16
);
  logic          i_en;
  logic [DW-1:0] i_target;
  logic          i_target_valid;
  logic          o_target_ready;
  logic [DW-1:0] i_step;
  logic [IW-1:0] i_interval;
  logic [DW-1:0] i_limit;
  logic [DW-1:0] o_DC;
  logic          o_DC_valid;
  logic          o_update;
  logic          o_busy;
  logic          o_done;
  logic          o_clamped;

  modport master (
    output i_en, i_target, i_target_valid, i_step, i_interval, i_limit,
    input  o_target_ready, o_DC, o_DC_valid, o_update, o_busy, o_done, o_clamped
  );

  modport slave (
    input  i_en, i_target, i_target_valid, i_step, i_interval, i_limit,
    output o_target_ready, o_DC, o_DC_valid, o_update, o_busy, o_done, o_clamped
  );
endinterface

// File: rtl/pwm_dc_ramp.sv
// Duty-cycle soft-start / slew generator for one PWM channel.
// Accepts a target, then walks o_DC toward it by a fixed step every
// (interval+1) clocks, saturating exactly on the target, then holds.
module pwm_dc_ramp #(
  parameter int DW = 16,
  parameter int IW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pwm_dc_ramp_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t        state, state_n;
  logic [DW-1:0] dc, dc_n;
  logic [DW-1:0] tgt, tgt_n;
  logic [DW-1:0] stp, stp_n;
  logic [IW-1:0] ivl, ivl_n;
  logic [IW-1:0] cnt, cnt_n;
  logic          dc_vld, dc_vld_n;
  logic          upd, upd_n;
  logic          done, done_n;
  logic          clamp, clamp_n;

  logic          accept;
  logic [DW-1:0] lim_tgt;
  logic [DW:0]   up_sum;
  logic [DW-1:0] dn_diff;
  logic [DW-1:0] step_dc;

  assign bus.o_target_ready = bus.i_en & (state != RAMP);
  assign accept             = bus.i_target_valid & bus.o_target_ready;
  assign lim_tgt            = (bus.i_target > bus.i_limit) ? bus.i_limit : bus.i_target;

  assign bus.o_DC       = dc;
  assign bus.o_DC_valid = dc_vld;
  assign bus.o_update   = upd;
  assign bus.o_done     = done;
  assign bus.o_clamped  = clamp;
  assign bus.o_busy     = (state == RAMP);

  // One slew step toward tgt; up path uses a carry bit so it cannot wrap.
  always_comb begin
    up_sum  = {1'b0, dc} + {1'b0, stp};
    dn_diff = dc - tgt;
    step_dc = dc;
    if (dc < tgt)
      step_dc = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DW-1:0];
    else
      step_dc = (dn_diff <= stp) ? tgt : (dc - stp);
  end

  // Next-state and next-datapath decode; disable wins over everything.
  always_comb begin
    state_n  = state;
    dc_n     = dc;
    tgt_n    = tgt;
    stp_n    = stp;
    ivl_n    = ivl;
    cnt_n    = cnt;
    dc_vld_n = dc_vld;
    clamp_n  = clamp;
    upd_n    = 1'b0;
    done_n   = 1'b0;
    if (!bus.i_en) begin
      state_n  = IDLE;
      dc_n     = '0;
      dc_vld_n = 1'b0;
      cnt_n    = '0;
    end else if (accept) begin
      tgt_n    = lim_tgt;
      stp_n    = (bus.i_step == '0) ? {{(DW-1){1'b0}}, 1'b1} : bus.i_step;
      ivl_n    = bus.i_interval;
      clamp_n  = (bus.i_target > bus.i_limit);
      dc_vld_n = 1'b1;
      cnt_n    = '0;
      if (lim_tgt == dc) begin
        state_n = HOLD;
        done_n  = 1'b1;
      end else begin
        state_n = RAMP;
      end
    end else if (state == RAMP) begin
      if (cnt == ivl) begin
        cnt_n = '0;
        dc_n  = step_dc;
        upd_n = 1'b1;
        if (step_dc == tgt) begin
          done_n  = 1'b1;
          state_n = HOLD;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dc     <= '0;
      tgt    <= '0;
      stp    <= '0;
      ivl    <= '0;
      cnt    <= '0;
      dc_vld <= 1'b0;
      upd    <= 1'b0;
      done   <= 1'b0;
      clamp  <= 1'b0;
    end else begin
      dc     <= dc_n;
      tgt    <= tgt_n;
      stp    <= stp_n;
      ivl    <= ivl_n;
      cnt    <= cnt_n;
      dc_vld <= dc_vld_n;
      upd    <= upd_n;
      done   <= done_n;
      clamp  <= clamp_n;
    end
  end

endmodule

// File: tb/tb_pwm_dc_ramp.sv
// Bench for pwm_dc_ramp: table of directed accepts, random accepts, and
// hand sequences for handshake stall, async reset and disable.
// Expected trajectories come from a closed-form model: after m updates the
// duty cycle is dc0 +/- m*step, saturated at the target.
module tb_pwm_dc_ramp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_dc_ramp_if #(.DW(16), .IW(16)) bus ();

  pwm_dc_ramp #(.DW(16), .IW(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_dc  = 0;   // model's view of current duty cycle

  typedef struct {
    int target;
    int step;
    int interval;
    int limit;
    int exp_final;
    int exp_clamp;
    int exp_upd;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // {dc, dc_valid, update, done, busy, ready, clamped}
  function automatic logic [31:0] snap();
    return {10'd0, bus.o_DC, bus.o_DC_valid, bus.o_update, bus.o_done,
            bus.o_busy, bus.o_target_ready, bus.o_clamped};
  endfunction

  function automatic logic [31:0] pack(input int dc, input bit vld, input bit upd,
                                       input bit dn, input bit bsy, input bit rdy,
                                       input bit clp);
    logic [15:0] d;
    d = dc[15:0];
    return {10'd0, d, vld, upd, dn, bsy, rdy, clp};
  endfunction

  // Issue one accept and check every cycle until the ramp settles.
  // keep=1 leaves valid asserted (with junk config) to probe the stall.
  task automatic run_accept(input int target, input int step, input int interval,
                            input int limit, input bit keep, output int nupd);
    int tgt, st, d, ns, p, total, kmax, m, e;
    bit up, clp, eupd, edone, ebusy;
    tgt   = (target > limit) ? limit : target;
    clp   = (target > limit);
    st    = (step == 0) ? 1 : step;
    up    = (tgt > m_dc);
    d     = up ? (tgt - m_dc) : (m_dc - tgt);
    ns    = (d + st - 1) / st;
    p     = interval + 1;
    total = ns * p;
    kmax  = (ns == 0) ? 1 : total;
    nupd  = 0;
    bus.i_target       = target[15:0];
    bus.i_step         = step[15:0];
    bus.i_interval     = interval[15:0];
    bus.i_limit        = limit[15:0];
    bus.i_target_valid = 1'b1;
    @(posedge clk); #1;
    if (keep) begin
      bus.i_target   = 16'd9;
      bus.i_step     = 16'd1;
      bus.i_interval = 16'd0;
      bus.i_limit    = 16'd0;
    end else begin
      bus.i_target_valid = 1'b0;
    end
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      m = k / p;
      if (m > ns) m = ns;
      e = up ? m_dc + m * st : m_dc - m * st;
      if (up && e > tgt) e = tgt;
      if (!up && e < tgt) e = tgt;
      eupd  = (ns > 0) && (k > 0) && (k % p == 0);
      edone = (ns == 0) ? (k == 0) : (k == total);
      ebusy = (ns > 0) && (k < total);
      chk($sformatf("cycle t=%0d k=%0d", target, k), snap(),
          pack(e, 1'b1, eupd, edone, ebusy, ~ebusy, clp));
      nupd += int'(bus.o_update);
    end
    m_dc = tgt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nu;
    int t, s, iv, lim;
    tv[0] = '{100,   10,    3, 65535, 100,   0, 10};
    tv[1] = '{35,    20,    0, 65535, 35,    0, 4};
    tv[2] = '{0,     65535, 0, 65535, 0,     0, 1};
    tv[3] = '{200,   50,    0, 120,   120,   1, 3};
    tv[4] = '{65530, 65535, 0, 65535, 65530, 0, 1};
    tv[5] = '{65535, 10,    5, 65535, 65535, 0, 1};
    tv[6] = '{65535, 7,     2, 65535, 65535, 0, 0};
    tv[7] = '{65532, 0,     0, 65535, 65532, 0, 3};
    tv[8] = '{5,     40000, 1, 0,     0,     1, 2};

    rst_n              = 1'b0;
    bus.i_en           = 1'b0;
    bus.i_target       = '0;
    bus.i_target_valid = 1'b0;
    bus.i_step         = '0;
    bus.i_interval     = '0;
    bus.i_limit        = '0;
    #12;
    chk("reset_state", snap(), pack(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n    = 1'b1;
    bus.i_en = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", snap(), pack(0, 0, 0, 0, 0, 1, 0));

    // Directed table, each entry starting where the previous one ended.
    for (int i = 0; i < 9; i++) begin
      run_accept(tv[i].target, tv[i].step, tv[i].interval, tv[i].limit, 1'b0, nu);
      chk($sformatf("vec%0d final_dc", i), {16'd0, bus.o_DC}, tv[i].exp_final);
      chk($sformatf("vec%0d clamped", i), {31'd0, bus.o_clamped}, tv[i].exp_clamp);
      chk($sformatf("vec%0d n_update", i), nu, tv[i].exp_upd);
    end

    // Request held during RAMP: stalls, junk inputs ignored, then accepted.
    run_accept(30, 10, 1, 65535, 1'b1, nu);
    run_accept(12, 4, 0, 65535, 1'b0, nu);
    chk("stall_final_dc", {16'd0, bus.o_DC}, 32'd12);
    chk("stall_n_update", nu, 32'd5);

    // Random accepts against the model.
    for (int i = 0; i < 20; i++) begin
      t   = int'($urandom_range(0, 65535));
      lim = ($urandom_range(0, 1) == 0) ? 65535 : int'($urandom_range(0, 65535));
      s   = int'($urandom_range(1000, 65535));
      iv  = int'($urandom_range(0, 3));
      run_accept(t, s, iv, lim, 1'b0, nu);
    end

    // Async reset between edges mid-ramp.
    bus.i_target       = (m_dc < 30000) ? 16'd60000 : 16'd0;
    bus.i_step         = 16'd100;
    bus.i_interval     = 16'd1;
    bus.i_limit        = 16'd65535;
    bus.i_target_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_target_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", snap(), pack(0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    m_dc  = 0;

    // Disable mid-ramp: clamped flag survives, ready low while disabled.
    run_accept(500, 100, 0, 300, 1'b0, nu);
    bus.i_target       = 16'd5000;
    bus.i_step         = 16'd100;
    bus.i_interval     = 16'd2;
    bus.i_limit        = 16'd4000;
    bus.i_target_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_target_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.i_en = 1'b0;
    #1 chk("dis_ready_comb", {31'd0, bus.o_target_ready}, 32'd0);
    @(posedge clk); #1;
    chk("dis_state", snap(), pack(0, 0, 0, 0, 0, 0, 1));
    bus.i_target_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("dis_hold k=%0d", k), snap(), pack(0, 0, 0, 0, 0, 0, 1));
    end
    bus.i_target_valid = 1'b0;
    bus.i_en           = 1'b1;
    m_dc               = 0;
    run_accept(77, 7, 0, 65535, 1'b0, nu);
    chk("recover_n_update", nu, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
